// File: rtl/mips_check_pkg.sv
// Shared types and constants for the MIPS store checker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_check_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ADR     = 2'd1,
        FC_DATA    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_t;

endpackage

// File: rtl/store_checker_table.sv
// Expected-store table: N_EXP entries of {address, data}, read at the current pointer.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none; writes are accepted whenever i_we is high.
module store_checker_table
    import mips_check_pkg::*;
#(
    parameter int N_EXP = 4,
    parameter int IDX_W = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [WORD_W-1:0] i_wadr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [WORD_W-1:0] o_radr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [2*WORD_W-1:0] r_mem [N_EXP];
    logic [2*WORD_W-1:0] w_rd;

    // Entry storage: cleared on reset, one entry written per edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_EXP; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= {i_wadr, i_wdata};
        end
    end

    // Combinational read of the entry under the pointer.
    always_comb begin
        w_rd    = r_mem[i_ridx];
        o_radr  = w_rd[2*WORD_W-1:WORD_W];
        o_rdata = w_rd[WORD_W-1:0];
    end

endmodule

// File: rtl/store_checker.sv
// Checks processor stores against a programmed expected sequence and reports a verdict.
// Latency: verdict registered, visible one cycle after the deciding store edge.
// Backpressure: none; the store bus is observed passively and never stalled.
module store_checker
    import mips_check_pkg::*;
#(
    parameter int                N_EXP       = 4,
    parameter int                IDX_W       = 2,
    parameter logic [WORD_W-1:0] SCRATCH_ADR = 32'd80,
    parameter int                TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [WORD_W-1:0] dataadr,
    input  logic [WORD_W-1:0] writedata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [WORD_W-1:0] cfg_adr,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [WORD_W-1:0] fail_adr,
    output logic [WORD_W-1:0] fail_data,
    output logic [15:0]       store_cnt,
    output logic [31:0]       cycle_cnt
);

    localparam logic [IDX_W:0] LP_N_EXP   = (IDX_W+1)'(N_EXP);
    localparam logic [31:0]    LP_TO_LAST = 32'(TIMEOUT - 1);

    chk_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W:0]    r_count;
    fail_code_t        r_fail_code;
    logic [WORD_W-1:0] r_fail_adr;
    logic [WORD_W-1:0] r_fail_data;
    logic [15:0]       r_store_cnt;
    logic [31:0]       r_cycle_cnt;

    logic              w_tbl_we;
    logic [WORD_W-1:0] w_exp_adr;
    logic [WORD_W-1:0] w_exp_data;
    logic [IDX_W:0]    w_count_clamped;
    fail_code_t        w_store_fc;
    logic              w_match;
    logic              w_final;

    // The table is frozen while a check is running; out-of-range indices are dropped.
    assign w_tbl_we = cfg_we && (r_state != RUN) && ({1'b0, cfg_idx} < LP_N_EXP);

    store_checker_table #(
        .N_EXP (N_EXP),
        .IDX_W (IDX_W)
    ) u_table (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_tbl_we),
        .i_widx  (cfg_idx),
        .i_wadr  (cfg_adr),
        .i_wdata (cfg_data),
        .i_ridx  (r_ptr),
        .o_radr  (w_exp_adr),
        .o_rdata (w_exp_data)
    );

    assign w_count_clamped = (cfg_count > LP_N_EXP) ? LP_N_EXP : cfg_count;

    // Classify the current store: scratch stores neither match nor mismatch.
    always_comb begin
        w_store_fc = FC_NONE;
        w_match    = 1'b0;
        w_final    = 1'b0;
        if (memwrite && (dataadr != SCRATCH_ADR)) begin
            if (dataadr != w_exp_adr) begin
                w_store_fc = FC_ADR;
            end else if (writedata != w_exp_data) begin
                w_store_fc = FC_DATA;
            end else begin
                w_match = 1'b1;
                w_final = ({1'b0, r_ptr} == (r_count - (IDX_W+1)'(1)));
            end
        end
    end

    // Checker FSM with counters and failure capture; store verdicts beat the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_fail_code <= FC_NONE;
            r_fail_adr  <= '0;
            r_fail_data <= '0;
            r_store_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    if (memwrite && (r_store_cnt != 16'hFFFF)) begin
                        r_store_cnt <= r_store_cnt + 16'd1;
                    end
                    if (w_match) begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                    if (w_store_fc != FC_NONE) begin
                        r_state     <= FAIL;
                        r_fail_code <= w_store_fc;
                        r_fail_adr  <= dataadr;
                        r_fail_data <= writedata;
                    end else if (w_final) begin
                        r_state <= PASS;
                    end else if (r_cycle_cnt == LP_TO_LAST) begin
                        r_state     <= FAIL;
                        r_fail_code <= FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        r_count     <= w_count_clamped;
                        r_ptr       <= '0;
                        r_store_cnt <= '0;
                        r_cycle_cnt <= '0;
                        r_fail_code <= FC_NONE;
                        r_fail_adr  <= '0;
                        r_fail_data <= '0;
                        r_state     <= (w_count_clamped == '0) ? PASS : RUN;
                    end
                end
            endcase
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == PASS) || (r_state == FAIL);
    assign pass      = (r_state == PASS);
    assign fail_code = r_fail_code;
    assign fail_adr  = r_fail_adr;
    assign fail_data = r_fail_data;
    assign store_cnt = r_store_cnt;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker with a behavioural reference checked every cycle.
// Latency: inputs driven 1 time unit after the rising edge; outputs compared on the falling edge.
// Backpressure: not applicable.
module tb_store_checker;

    localparam int TB_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_adr = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  cfg_count = '0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] fail_adr, fail_data;
    logic [15:0] store_cnt;
    logic [31:0] cycle_cnt;

    int vectors = 0;
    int miscompares = 0;

    store_checker #(
        .N_EXP       (4),
        .IDX_W       (2),
        .SCRATCH_ADR (32'd80),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_adr   (cfg_adr),
        .cfg_data  (cfg_data),
        .cfg_count (cfg_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code),
        .fail_adr  (fail_adr),
        .fail_data (fail_data),
        .store_cnt (store_cnt),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 checking, 2 passed, 3 failed
    int          m_phase;
    logic [31:0] m_exp_adr [4];
    logic [31:0] m_exp_dat [4];
    int          m_len, m_next;
    int          m_stores, m_cycles, m_code;
    logic [31:0] m_fadr, m_fdat;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_len = 0; m_next = 0; m_stores = 0; m_cycles = 0;
            m_code = 0; m_fadr = 0; m_fdat = 0;
            for (int i = 0; i < 4; i++) begin
                m_exp_adr[i] = 0; m_exp_dat[i] = 0;
            end
            m_valid = 1'b1;
        end else if (m_phase != 1) begin
            if (cfg_we) begin
                m_exp_adr[cfg_idx] = cfg_adr;
                m_exp_dat[cfg_idx] = cfg_data;
            end
            if (start) begin
                m_len = (int'(cfg_count) > 4) ? 4 : int'(cfg_count);
                m_next = 0; m_stores = 0; m_cycles = 0;
                m_code = 0; m_fadr = 0; m_fdat = 0;
                m_phase = (m_len == 0) ? 2 : 1;
            end
        end else begin
            bit decided;
            decided = 1'b0;
            if (memwrite) begin
                if (m_stores < 65535) m_stores++;
                if (dataadr == 32'd80) begin
                    // scratch store: accepted silently
                end else if (dataadr != m_exp_adr[m_next]) begin
                    m_phase = 3; m_code = 1; m_fadr = dataadr; m_fdat = writedata; decided = 1'b1;
                end else if (writedata != m_exp_dat[m_next]) begin
                    m_phase = 3; m_code = 2; m_fadr = dataadr; m_fdat = writedata; decided = 1'b1;
                end else begin
                    m_next++;
                    if (m_next == m_len) begin
                        m_phase = 2; decided = 1'b1;
                    end
                end
            end
            if (!decided && m_cycles == TB_TIMEOUT - 1) begin
                m_phase = 3; m_code = 3;
            end
            m_cycles++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",      32'(busy),      32'(m_phase == 1));
            chk("done",      32'(done),      32'(m_phase >= 2));
            chk("pass",      32'(pass),      32'(m_phase == 2));
            chk("fail_code", 32'(fail_code), 32'(m_code));
            chk("fail_adr",  fail_adr,       m_fadr);
            chk("fail_data", fail_data,      m_fdat);
            chk("store_cnt", 32'(store_cnt), 32'(m_stores));
            chk("cycle_cnt", cycle_cnt,      32'(m_cycles));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_store_cnt", 32'(store_cnt), 32'd0);

        // scratch stores accepted, single match passes
        cfg(2'd0, 32'd84, 32'd7);
        cfg_count = 3'd1;
        go();
        st(32'd80, 32'd5);
        st(32'd80, 32'd9);
        chk("t1_busy_before", 32'(busy), 32'd1);
        st(32'd84, 32'd7);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_store_cnt", 32'(store_cnt), 32'd3);
        chk("t1_code", 32'(fail_code), 32'd0);

        // store outside RUN is ignored
        st(32'd84, 32'd7);
        chk("t1_idle_store", 32'(store_cnt), 32'd3);

        // address mismatch
        go();
        st(32'd88, 32'd7);
        chk("t2_code", 32'(fail_code), 32'd1);
        chk("t2_adr", fail_adr, 32'd88);
        chk("t2_data", fail_data, 32'd7);

        // data mismatch
        go();
        st(32'd84, 32'd6);
        chk("t3_code", 32'(fail_code), 32'd2);
        chk("t3_adr", fail_adr, 32'd84);
        chk("t3_data", fail_data, 32'd6);

        // timeout with no stores
        go();
        repeat (TB_TIMEOUT - 1) tick();
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_cyc_at_decision", cycle_cnt, 32'd19);
        tick();
        chk("t4_code", 32'(fail_code), 32'd3);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_adr", fail_adr, 32'd0);

        // reset mid-run aborts, table cleared, replay passes
        cfg(2'd1, 32'd100, 32'd3);
        cfg_count = 3'd2;
        go();
        st(32'd84, 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_cyc", cycle_cnt, 32'd0);
        cfg(2'd0, 32'd84, 32'd7);
        cfg(2'd1, 32'd100, 32'd3);
        go();
        st(32'd84, 32'd7);
        chk("t5_mid_busy", 32'(busy), 32'd1);
        st(32'd100, 32'd3);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_store_cnt", 32'(store_cnt), 32'd2);

        // count=0 passes immediately
        cfg_count = 3'd0;
        go();
        chk("t6_pass0", 32'(pass), 32'd1);
        chk("t6_cyc0", cycle_cnt, 32'd0);

        // cfg_we during RUN ignored
        cfg_count = 3'd1;
        go();
        cfg(2'd0, 32'd84, 32'd99);
        st(32'd84, 32'd7);
        chk("t6_pass_frozen", 32'(pass), 32'd1);

        // count above N_EXP clamps to 4 entries
        cfg(2'd2, 32'd104, 32'd11);
        cfg(2'd3, 32'd108, 32'd12);
        cfg_count = 3'd7;
        go();
        st(32'd84, 32'd7);
        st(32'd100, 32'd3);
        st(32'd104, 32'd11);
        st(32'd108, 32'd12);
        chk("t7_pass", 32'(pass), 32'd1);
        chk("t7_store_cnt", 32'(store_cnt), 32'd4);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
